// File: rtl/eeprom_req_arbiter.sv
// rtl/eeprom_req_arbiter.sv - two-requester round-robin arbiter for a serial EEPROM engine
//
// Purpose: grants one of requesters A/B to the EEPROM engine, holds the engine
// WR/RD level until eng_ack_i, returns read data, and enforces an idle gap of
// WR_GAP_CYC cycles after every write so the EEPROM can finish its internal
// write cycle. All outputs are registered.
//
// Optional feature: define EEARB_TIMEOUT_EN to abort a WAIT that sees no
// eng_ack_i within TIMEOUT_CYC cycles (done pulses with err=1).
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   {a,b}_req_i                request level, held until done
//   {a,b}_we_i/addr_i/wdata_i  op descriptor, stable while req is high
//   {a,b}_done_o               one-cycle completion pulse
//   {a,b}_err_o                timeout flag, valid with done
//   {a,b}_rdata_o              last read byte for that requester
//   eng_wr_o/eng_rd_o          engine command levels
//   eng_addr_o/eng_wdata_o     engine address / write byte
//   eng_rdata_i/eng_ack_i      engine read byte / cycle-complete pulse
//   busy_o                     high in every state except IDLE

module eeprom_req_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 16,
  parameter int WR_GAP_CYC  = 1000,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_done_o,
  output logic              a_err_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_done_o,
  output logic              b_err_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              eng_wr_o,
  output logic              eng_rd_o,
  output logic [ADDR_W-1:0] eng_addr_o,
  output logic [DATA_W-1:0] eng_wdata_o,
  input  logic [DATA_W-1:0] eng_rdata_i,
  input  logic              eng_ack_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_GAP} state_t;

  state_t            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;   // 1 = B was granted last
  logic              gnt_q, gnt_d;             // owner of current op, 1 = B
  logic              we_q, we_d;
  logic              eng_wr_q, eng_wr_d, eng_rd_q, eng_rd_d;
  logic [ADDR_W-1:0] eng_addr_q, eng_addr_d;
  logic [DATA_W-1:0] eng_wdata_q, eng_wdata_d;
  logic              a_done_q, a_done_d, b_done_q, b_done_d;
  logic              a_err_q, a_err_d, b_err_q, b_err_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              pick_b;
  logic              tmo_hit;

`ifdef EEARB_TIMEOUT_EN
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  // Counter holds (WAIT cycles - 1), so this fires on the TIMEOUT_CYC-th cycle.
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic              unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^(CNT_W'(TIMEOUT_CYC));
`endif

  // On a tie the requester that was not granted last wins.
  assign pick_b = b_req_i && (!a_req_i || !last_gnt_q);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      last_gnt_q  <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      eng_wr_q    <= 1'b0;
      eng_rd_q    <= 1'b0;
      eng_addr_q  <= '0;
      eng_wdata_q <= '0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      busy_q      <= 1'b0;
      gap_cnt_q   <= '0;
`ifdef EEARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      eng_wr_q    <= eng_wr_d;
      eng_rd_q    <= eng_rd_d;
      eng_addr_q  <= eng_addr_d;
      eng_wdata_q <= eng_wdata_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      a_err_q     <= a_err_d;
      b_err_q     <= b_err_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      busy_q      <= busy_d;
      gap_cnt_q   <= gap_cnt_d;
`ifdef EEARB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (a_req_i || b_req_i) state_d = S_WAIT;
      S_WAIT:  if (eng_ack_i || tmo_hit) state_d = S_DONE;
      S_DONE:  state_d = (we_q && (WR_GAP_CYC > 0)) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_gnt_d  = last_gnt_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    eng_wr_d    = eng_wr_q;
    eng_rd_d    = eng_rd_q;
    eng_addr_d  = eng_addr_q;
    eng_wdata_d = eng_wdata_q;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;
    a_err_d     = 1'b0;
    b_err_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    gap_cnt_d   = gap_cnt_q;
`ifdef EEARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (a_req_i || b_req_i) begin
          gnt_d       = pick_b;
          last_gnt_d  = pick_b;
          we_d        = pick_b ? b_we_i    : a_we_i;
          eng_addr_d  = pick_b ? b_addr_i  : a_addr_i;
          eng_wdata_d = pick_b ? b_wdata_i : a_wdata_i;
          eng_wr_d    = pick_b ? b_we_i    : a_we_i;
          eng_rd_d    = pick_b ? !b_we_i   : !a_we_i;
`ifdef EEARB_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (eng_ack_i || tmo_hit) begin
          eng_wr_d = 1'b0;
          eng_rd_d = 1'b0;
          a_done_d = !gnt_q;
          b_done_d = gnt_q;
          // Ack wins over a timeout landing on the same cycle.
          a_err_d  = !eng_ack_i && !gnt_q;
          b_err_d  = !eng_ack_i && gnt_q;
          if (eng_ack_i && !we_q) begin
            if (gnt_q) b_rdata_d = eng_rdata_i;
            else       a_rdata_d = eng_rdata_i;
          end
        end else begin
`ifdef EEARB_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      S_DONE: begin
        if (we_q && (WR_GAP_CYC > 0)) gap_cnt_d = CNT_W'(WR_GAP_CYC - 1);
      end
      S_GAP: begin
        if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign a_done_o    = a_done_q;
  assign b_done_o    = b_done_q;
  assign a_err_o     = a_err_q;
  assign b_err_o     = b_err_q;
  assign a_rdata_o   = a_rdata_q;
  assign b_rdata_o   = b_rdata_q;
  assign eng_wr_o    = eng_wr_q;
  assign eng_rd_o    = eng_rd_q;
  assign eng_addr_o  = eng_addr_q;
  assign eng_wdata_o = eng_wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_eeprom_req_arbiter.sv
// tb/tb_eeprom_req_arbiter.sv - self-checking bench for eeprom_req_arbiter

module tb_eeprom_req_arbiter;
  localparam int AW  = 11;
  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int GAP = 8;
  localparam int TMO = 16;
`ifdef EEARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RESET;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_done, a_err, b_done, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          eng_wr, eng_rd, eng_ack, busy;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_wdata, eng_rdata;

  eeprom_req_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .WR_GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_done_o(a_done), .a_err_o(a_err), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_done_o(b_done), .b_err_o(b_err), .b_rdata_o(b_rdata),
    .eng_wr_o(eng_wr), .eng_rd_o(eng_rd), .eng_addr_o(eng_addr),
    .eng_wdata_o(eng_wdata), .eng_rdata_i(eng_rdata), .eng_ack_i(eng_ack),
    .busy_o(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 60)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an op in flight, a pending done pulse,
  // and a count of recovery cycles still owed after a write.
  bit          m_cmd, m_we, m_who, m_done, m_err, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata [2];
  int          m_gap, m_wait;
  bit          chk_en = 1'b0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_cmd = 0; m_done = 0; m_err = 0; m_gap = 0; m_wait = 0;
      m_last = 1; m_we = 0; m_who = 0;
      m_rdata[0] = '0; m_rdata[1] = '0;
    end else if (m_cmd) begin
      if (eng_ack) begin
        m_cmd = 0; m_done = 1; m_err = 0;
        if (!m_we) m_rdata[m_who] = eng_rdata;
      end else if (TMO_ON && (m_wait + 1 == TMO)) begin
        m_cmd = 0; m_done = 1; m_err = 1;
      end else begin
        m_wait++;
      end
    end else if (m_done) begin
      m_done = 0; m_err = 0;
      if (m_we) m_gap = GAP;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (a_req || b_req) begin
      if (a_req && b_req) m_who = !m_last;
      else                m_who = b_req;
      m_last  = m_who;
      m_cmd   = 1;
      m_wait  = 0;
      m_we    = m_who ? b_we    : a_we;
      m_addr  = m_who ? b_addr  : a_addr;
      m_wdata = m_who ? b_wdata : a_wdata;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("m_eng_wr", eng_wr, m_cmd && m_we);
      check("m_eng_rd", eng_rd, m_cmd && !m_we);
      check("m_busy",   busy,   m_cmd || m_done || (m_gap > 0));
      check("m_a_done", a_done, m_done && !m_who);
      check("m_b_done", b_done, m_done && m_who);
      check("m_a_err",  a_err,  m_done && !m_who && m_err);
      check("m_b_err",  b_err,  m_done && m_who && m_err);
      check("m_a_rdata", a_rdata, m_rdata[0]);
      check("m_b_rdata", b_rdata, m_rdata[1]);
      if (m_cmd) begin
        check("m_eng_addr", eng_addr, m_addr);
        if (m_we) check("m_eng_wdata", eng_wdata, m_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cmd(input string nm);
    int n = 0;
    while (!(eng_wr || eng_rd) && n < 50) begin
      tick();
      n++;
    end
    check(nm, eng_wr || eng_rd, 1);
  endtask

  task automatic ack_pulse(input logic [DW-1:0] rd);
    eng_rdata = rd;
    eng_ack   = 1'b1;
    tick();
    eng_ack   = 1'b0;
    eng_rdata = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < GAP + 20) begin
      n++;
      tick();
    end
  endtask

  int n;
  logic order [4];

  initial begin
    RESET = 1'b1; eng_ack = 1'b0; eng_rdata = '0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    tick();
    chk_en = 1'b1;
    tick();
    RESET = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_eng_wr", eng_wr, 0);
    check("rst_a_rdata", a_rdata, 0);

    // 1: A write, then recovery gap
    a_we = 1; a_addr = 11'h155; a_wdata = 8'hA5; a_req = 1;
    tick();
    check("t1_eng_wr", eng_wr, 1);
    check("t1_eng_addr", eng_addr, 11'h155);
    check("t1_eng_wdata", eng_wdata, 8'hA5);
    tick(); tick();
    ack_pulse('0);
    check("t1_a_done", a_done, 1);
    check("t1_b_done", b_done, 0);
    a_req = 0;
    tick();
    count_busy(n);
    check("t1_gap_len", n, GAP);

    // 2: B read, no gap afterwards
    b_we = 0; b_addr = 11'h7FF; b_req = 1;
    tick();
    check("t2_eng_rd", eng_rd, 1);
    check("t2_eng_addr", eng_addr, 11'h7FF);
    tick();
    ack_pulse(8'h3C);
    check("t2_b_done", b_done, 1);
    check("t2_b_rdata", b_rdata, 8'h3C);
    b_req = 0;
    tick();
    check("t2_idle_after_done", busy, 0);

    // 3: simultaneous requests after reset alternate A,B,A,B
    RESET = 1; tick(); RESET = 0;
    a_we = 0; b_we = 0; a_addr = 11'h011; b_addr = 11'h022;
    a_req = 1; b_req = 1;
    for (int i = 0; i < 4; i++) begin
      wait_cmd("t3_cmd");
      tick();
      ack_pulse(8'h10 + 8'(i));
      order[i] = b_done;
    end
    a_req = 0; b_req = 0;
    tick(); tick();
    check("t3_order0", order[0], 0);
    check("t3_order1", order[1], 1);
    check("t3_order2", order[2], 0);
    check("t3_order3", order[3], 1);
    check("t3_a_rdata", a_rdata, 8'h12);
    check("t3_b_rdata", b_rdata, 8'h13);

    // 4: B read requested during A's write gap
    a_we = 1; a_addr = 11'h100; a_wdata = 8'h5A; a_req = 1;
    wait_cmd("t4_cmd");
    tick();
    ack_pulse('0);
    a_req = 0;
    tick();
    b_we = 0; b_addr = 11'h0AA; b_req = 1;
    count_busy(n);
    check("t4_gap_len", n, GAP);
    check("t4_idle_rd", eng_rd, 0);
    tick();
    check("t4_rd_rise", eng_rd, 1);
    tick();
    ack_pulse(8'h77);
    check("t4_b_done", b_done, 1);
    b_req = 0;
    tick(); tick();

    // 5: reset while in WAIT
    a_we = 1; a_addr = 11'h033; a_wdata = 8'h11; a_req = 1;
    wait_cmd("t5_cmd");
    tick();
    RESET = 1; a_req = 0;
    tick();
    check("t5_eng_wr", eng_wr, 0);
    check("t5_eng_rd", eng_rd, 0);
    check("t5_busy", busy, 0);
    check("t5_a_done", a_done, 0);
    check("t5_a_rdata", a_rdata, 0);
    RESET = 0;
    a_we = 0; a_addr = 11'h044; a_req = 1;
    wait_cmd("t5_fresh_cmd");
    tick();
    ack_pulse(8'h99);
    check("t5_fresh_done", a_done, 1);
    check("t5_fresh_rdata", a_rdata, 8'h99);
    a_req = 0;
    tick(); tick();

    // 7: stray ack in IDLE ignored; requester dropping mid-op still gets done
    eng_ack = 1; tick(); eng_ack = 0;
    check("t7_idle_ack_busy", busy, 0);
    check("t7_idle_ack_done", a_done, 0);
    b_we = 1; b_addr = 11'h200; b_wdata = 8'hC3; b_req = 1;
    tick();
    b_req = 0;
    check("t7_eng_wr", eng_wr, 1);
    tick();
    ack_pulse('0);
    check("t7_b_done", b_done, 1);
    tick();
    count_busy(n);
    check("t7_gap_len", n, GAP);

    // 6: engine never acks
    a_we = 0; a_addr = 11'h066; a_req = 1;
    wait_cmd("t6_cmd");
    n = 0;
    while (eng_rd && n < 40) begin
      n++;
      tick();
    end
`ifdef EEARB_TIMEOUT_EN
    check("t6_wait_len", n, TMO);
    check("t6_a_done", a_done, 1);
    check("t6_a_err", a_err, 1);
    check("t6_a_rdata_kept", a_rdata, 8'h99);
    a_req = 0;
    tick(); tick();
`else
    check("t6_wait_len", n, 40);
    check("t6_busy", busy, 1);
    RESET = 1; a_req = 0;
    tick();
    RESET = 0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
